pipe_stage_skid_reg: RTL and testbench

//   Elastic pipeline-stage register with a valid/ready handshake. Parametrised replacement for the

---
 rtl/pipe_stage_skid_reg.sv | 88 ++++++++
 tb/tb_pipe_stage_skid_reg.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid_reg.sv
// Elastic pipeline-stage register: main entry plus one skid entry, so in_ready comes
// straight from a flop and back-to-back transfers survive a one-cycle stall.
module pipe_stage_skid_reg #(
  parameter int                 DATA_W     = 64,
  parameter logic [DATA_W-1:0]  PRESET_VAL = '0
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              load_main_in, load_main_skid, load_skid;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_valid) begin
          load_main_in = 1'b1;
          state_nxt    = BUSY;
        end
      end
      BUSY: begin
        if (in_valid && out_ready) begin
          load_main_in = 1'b1;
        end else if (in_valid) begin
          load_skid = 1'b1;
          state_nxt = FULL;
        end else if (out_ready) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so upstream data is not looked at.
        if (out_ready) begin
          load_main_skid = 1'b1;
          state_nxt      = BUSY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= EMPTY;
      main_data <= PRESET_VAL;
      skid_data <= PRESET_VAL;
    end else if (flush) begin
      state     <= EMPTY;
      main_data <= PRESET_VAL;
      skid_data <= PRESET_VAL;
    end else begin
      state <= state_nxt;
      if (load_main_in)
        main_data <= in_data;
      else if (load_main_skid)
        main_data <= skid_data;
      if (load_skid)
        skid_data <= in_data;
    end
  end

  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != FULL);
  assign occupancy = state;
  assign out_data  = main_data;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed vector table, hand-written reset sequence, then a random run against a queue model.
module tb_pipe_stage_skid_reg;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         arst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;
  logic [67:0]  dut_st;

  int errors = 0;
  int checks = 0;

  pipe_stage_skid_reg #(.DATA_W(W), .PRESET_VAL('0)) dut (
    .clk(clk), .arst_n(arst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  assign dut_st = {out_valid, in_ready, occupancy, out_data};

  function automatic logic [67:0] st(logic ov, logic ir, logic [1:0] occ, logic [W-1:0] od);
    return {ov, ir, occ, od};
  endfunction

  task automatic chk(string nm, logic [67:0] act, logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got ov=%0b ir=%0b occ=%0d data=%h, want ov=%0b ir=%0b occ=%0d data=%h",
               nm, act[67], act[66], act[65:64], act[63:0], exp[67], exp[66], exp[65:64], exp[63:0]);
    end
  endtask

  typedef struct {
    logic         fl;
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic [67:0]  exp;
  } vec_t;

  localparam int NV = 18;
  vec_t tv[NV];

  logic [W-1:0] q[$];
  logic         r_iv, r_or, r_fl;
  logic [W-1:0] r_d;
  logic [67:0]  m_st;

  initial begin
    // streaming
    tv[0]  = '{1'b0, 1'b1, 64'h11, 1'b1, st(1, 1, 1, 64'h11)};
    tv[1]  = '{1'b0, 1'b1, 64'h22, 1'b1, st(1, 1, 1, 64'h22)};
    tv[2]  = '{1'b0, 1'b1, 64'h33, 1'b1, st(1, 1, 1, 64'h33)};
    tv[3]  = '{1'b0, 1'b0, 64'h0,  1'b1, st(0, 1, 0, 64'h33)};
    // back-pressure into skid
    tv[4]  = '{1'b0, 1'b1, 64'hA1, 1'b0, st(1, 1, 1, 64'hA1)};
    tv[5]  = '{1'b0, 1'b1, 64'hB2, 1'b0, st(1, 0, 2, 64'hA1)};
    // ignored while full
    tv[6]  = '{1'b0, 1'b1, 64'hCC, 1'b0, st(1, 0, 2, 64'hA1)};
    tv[7]  = '{1'b0, 1'b1, 64'hCC, 1'b0, st(1, 0, 2, 64'hA1)};
    tv[8]  = '{1'b0, 1'b1, 64'hCC, 1'b0, st(1, 0, 2, 64'hA1)};
    // drain
    tv[9]  = '{1'b0, 1'b0, 64'h0,  1'b1, st(1, 1, 1, 64'hB2)};
    tv[10] = '{1'b0, 1'b0, 64'h0,  1'b1, st(0, 1, 0, 64'hB2)};
    // flush while full, with a live input
    tv[11] = '{1'b0, 1'b1, 64'h5,  1'b0, st(1, 1, 1, 64'h5)};
    tv[12] = '{1'b0, 1'b1, 64'h6,  1'b0, st(1, 0, 2, 64'h5)};
    tv[13] = '{1'b1, 1'b1, 64'h7,  1'b0, st(0, 1, 0, 64'h0)};
    // flush while empty
    tv[14] = '{1'b1, 1'b1, 64'h9,  1'b1, st(0, 1, 0, 64'h0)};
    // hold in BUSY, then flush beating an output transfer
    tv[15] = '{1'b0, 1'b1, 64'h44, 1'b0, st(1, 1, 1, 64'h44)};
    tv[16] = '{1'b0, 1'b0, 64'h0,  1'b0, st(1, 1, 1, 64'h44)};
    tv[17] = '{1'b1, 1'b0, 64'h0,  1'b1, st(0, 1, 0, 64'h0)};

    #12;
    chk("reset_state", dut_st, st(0, 1, 0, 64'h0));
    #1 arst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      flush     = tv[i].fl;
      in_valid  = tv[i].iv;
      in_data   = tv[i].d;
      out_ready = tv[i].ordy;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), dut_st, tv[i].exp);
    end

    // Asynchronous reset landing in the middle of a FULL cycle.
    flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0; in_data = 64'hA;
    @(posedge clk); #1;
    in_data = 64'hB;
    @(posedge clk); #1;
    chk("prefill_full", dut_st, st(1, 0, 2, 64'hA));
    #2 arst_n = 1'b0;
    #1 chk("async_reset", dut_st, st(0, 1, 0, 64'h0));
    in_data = 64'h77;
    #2 arst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_edge_after_reset", dut_st, st(1, 1, 1, 64'h77));

    // Random traffic against a FIFO model of at most two entries.
    q.delete();
    q.push_back(64'h77);
    for (int c = 0; c < 10000; c++) begin
      m_st = st(q.size() > 0, q.size() < 2, 2'(q.size()), (q.size() > 0) ? q[0] : out_data);
      if (occupancy == 2'd3) chk("occ_illegal", dut_st, m_st ^ 68'h1_0000_0000_0000_0000);
      else                   chk("random", dut_st, m_st);
      r_iv = ($urandom_range(0, 3) != 0);
      r_or = ($urandom_range(0, 2) != 0);
      r_fl = ($urandom_range(0, 31) == 0);
      r_d  = {$urandom, $urandom};
      flush = r_fl; in_valid = r_iv; out_ready = r_or; in_data = r_d;
      @(posedge clk);
      if (r_fl) begin
        q.delete();
      end else begin
        logic pop, push;
        pop  = (q.size() > 0) && r_or;
        push = r_iv && (q.size() < 2);
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(r_d);
      end
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
